instr_queue: RTL
================

Name: instr_queue

Overview:
- Circular instruction buffer between fetch and the issue stage.
- Accepts fetched instructions with their PCs and presents the head entry to issue.
- Dequeues the head only when issue does not assert stall.
- After a control-transfer instruction is dequeued, holds further dequeue until the branch resolves, and drives br_stall to issue. Supports a full flush on mispredict.

Parameters:
- DEPTH, 8, number of entries; power of two.
- ADDR_W, 3, log2(DEPTH); pointer width.
- NOP_INSTR, 32'h47FF041F, encoding driven on instruction when no valid entry is presented (bis r31,r31,r31).

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- fetch_valid  in  1  fetch presents an instruction this cycle
- fetch_instr  in  32  fetched instruction word
- fetch_pc  in  32  PC of fetch_instr
- fetch_ready  out  1  queue can accept a push this cycle
- stall  in  1  from issue; 1 = head not consumed this cycle
- flush  in  1  discard all entries and any pending branch wait
- br_resolved  in  1  pulse from branch unit; ends branch wait
- instruction  out  32  head instruction to issue
- inst_pc  out  32  PC of head instruction
- inst_valid  out  1  instruction/inst_pc hold a real entry
- br_stall  out  1  branch outstanding; issue must hold
- count  out  ADDR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Storage:
  - DEPTH x (32-bit instr + 32-bit PC) array.
  - head and tail pointers ADDR_W bits wide; wrap naturally from DEPTH-1 to 0.
  - count register ADDR_W+1 bits wide.
- Reset: head=0, tail=0, count=0, state=RUN. Consequently fetch_ready=1, inst_valid=0, br_stall=0, instruction=NOP_INSTR, inst_pc=0. Array contents are don't-care.
- fetch_ready = (count != DEPTH). Combinational; no dependence on a same-cycle pop. A full queue refuses a push even while popping.
- push = fetch_valid & fetch_ready & ~flush. On push, writes entry[tail] and increments tail.
- inst_valid = (count != 0) & (state == RUN). Combinational.
- instruction / inst_pc:
  - When inst_valid=1: entry[head].
  - Otherwise: NOP_INSTR / 0.
- pop = inst_valid & ~stall & ~flush. On pop, increments head.
- count update:
  - push only: +1
  - pop only: -1
  - both: unchanged
  - neither: unchanged
- No bypass: a push into an empty queue becomes visible on inst_valid the following cycle (1-cycle latency fetch->issue).
- Branch detect: head opcode instruction[31:26] in {6'b111001 beq, 6'b111101 bne, 6'b110000 br, 6'b110100 bsr, 6'b011010 jmp/jsr/ret}.
- State machine, 2 states:
  - RUN: br_stall=0. On pop of a branch-class instruction -> BR_WAIT next cycle.
  - BR_WAIT: br_stall=1, inst_valid=0, no pop. Pushes continue normally. br_resolved=1 -> RUN next cycle; the next head is then presented in that cycle.
  - br_resolved while in RUN is ignored.
- flush (highest priority, below reset):
  - Next cycle: head=tail=0, count=0, state=RUN.
  - A same-cycle push or pop is discarded.
  - A same-cycle br_resolved is irrelevant.
- reset asserted mid-operation overrides flush, push and pop. Reset values apply on the next edge.
- Outputs other than through count/state are purely combinational from registered state plus stall/flush; no combinational path from fetch_* to issue-side outputs.

Test Plan:
- Reset, then push A (pc 0x100), stall=0 -> inst_valid=0 in the push cycle. Next cycle instruction=A, inst_pc=0x100, count=1; the following cycle count=0, instruction=NOP_INSTR.
- Push 8 instructions with stall=1 -> count=8, fetch_ready=0. A 9th fetch_valid is refused and count stays 8. Release stall -> the 8 entries exit in order, one per cycle.
- Push 5, pop 5, push 6 with stall toggling -> tail wraps past 7; output order matches push order. count never exceeds 8 or underflows.
- Queue holds beq (0xE4000000) then addq. beq popped -> br_stall=1, inst_valid=0 next cycle; addq held. br_resolved pulse after 3 cycles -> the cycle after, br_stall=0 and instruction=addq.
- Queue holds 4 entries in BR_WAIT; assert flush together with fetch_valid -> next cycle count=0, br_stall=0, inst_valid=0, instruction=NOP_INSTR. The pushed word is discarded.
- Queue holds 3 entries; assert reset together with fetch_valid and stall=0 -> next cycle count=0, fetch_ready=1, all outputs at reset values.

Source files
------------

// File: rtl/instr_queue.sv
// Circular instruction buffer between fetch and issue. It presents the head entry to issue,
// holds issue after a control-transfer instruction until the branch resolves, and empties on flush.
module instr_queue #(
  parameter int          DEPTH     = 8,
  parameter int          ADDR_W    = 3,
  parameter logic [31:0] NOP_INSTR = 32'h47FF041F
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  input  logic [31:0]       fetch_instr,
  input  logic [31:0]       fetch_pc,
  output logic              fetch_ready,
  input  logic              stall,
  input  logic              flush,
  input  logic              br_resolved,
  output logic [31:0]       instruction,
  output logic [31:0]       inst_pc,
  output logic              inst_valid,
  output logic              br_stall,
  output logic [ADDR_W:0]   count
);

  typedef enum logic {
    RUN     = 1'b0,
    BR_WAIT = 1'b1
  } state_e;

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       instr_mem_q [DEPTH];
  logic [31:0]       instr_mem_d [DEPTH];
  logic [31:0]       pc_mem_q    [DEPTH];
  logic [31:0]       pc_mem_d    [DEPTH];

  logic        push;
  logic        pop;
  logic        head_is_branch;
  logic [31:0] head_instr;
  logic [31:0] head_pc;

  assign head_instr = instr_mem_q[head_q];
  assign head_pc    = pc_mem_q[head_q];

  assign fetch_ready = (count_q != FULL_COUNT);
  assign inst_valid  = (count_q != '0) && (state_q == RUN);
  assign br_stall    = (state_q == BR_WAIT);
  assign count       = count_q;
  assign instruction = inst_valid ? head_instr : NOP_INSTR;
  assign inst_pc     = inst_valid ? head_pc : 32'h0;

  assign push = fetch_valid & fetch_ready & ~flush;
  assign pop  = inst_valid & ~stall & ~flush;

  // Control-transfer opcodes: beq, bne, br, bsr and the jmp/jsr/ret group
  always_comb begin
    head_is_branch = 1'b0;
    case (head_instr[31:26])
      6'b111001, 6'b111101, 6'b110000, 6'b110100, 6'b011010: head_is_branch = 1'b1;
      default: head_is_branch = 1'b0;
    endcase
  end

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    state_d     = state_q;
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;

    if (push) begin
      instr_mem_d[tail_q] = fetch_instr;
      pc_mem_d[tail_q]    = fetch_pc;
      tail_d              = tail_q + PTR_ONE;
    end
    if (pop) begin
      head_d = head_q + PTR_ONE;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    case (state_q)
      RUN: begin
        if (pop && head_is_branch) begin
          state_d = BR_WAIT;
        end
      end
      BR_WAIT: begin
        if (br_resolved) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    // Flush discards everything, including a same-cycle push, pop or branch wait
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= RUN;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    instr_mem_q <= instr_mem_d;
    pc_mem_q    <= pc_mem_d;
  end

endmodule
